reg_file_scoreboard: RTL
========================

# reg_file_scoreboard

Parametrised multi-read-port register file with a per-register busy scoreboard, intended as the register stage of the pipelined datapath. It generalises the single-write, two-read register file to NUMRDPORTS read ports, adds optional same-cycle write-to-read bypass, and tracks outstanding destination registers. Issue logic reserves a register before the producing instruction completes. Writeback clears the reservation. Register 0 always reads zero and is never busy.

## Interface
- WIDTH, 32, data width of each register
- NUMOFREGS, 32, number of registers (power of two, ≥ 4); AW = $clog2(NUMOFREGS)
- NUMRDPORTS, 2, number of read ports (1–8)
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see pre-edge contents
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- regWrite  input  1  write enable
- wreg  input  AW  write address
- wdata  input  WIDTH  write data
- rreg  input  NUMRDPORTS*AW  packed read addresses; port p = rreg[p*AW +: AW]
- rdata  output  NUMRDPORTS*WIDTH  packed read data; port p = rdata[p*WIDTH +: WIDTH]
- rbusy  output  NUMRDPORTS  busy flag of each port's addressed register
- reserve  input  1  request to mark rsvReg busy
- rsvReg  input  AW  register to reserve
- rsvGrant  output  1  reservation accepted this cycle (combinational)
- flush  input  1  synchronous clear of all busy bits
- busyCount  output  AW+1  number of registers currently busy

## Operation
- Storage: NUMOFREGS×WIDTH flops plus NUMOFREGS busy bits. Entry 0 data and busy are constant 0.
- Write: on the rising edge with regWrite=1 and wreg≠0, reg[wreg] ← wdata and busy[wreg] ← 0.
  - Writes to reg 0 are ignored.
  - A write to a non-busy register is legal and leaves busy at 0.
- Read (combinational, per port p):
  - rdata_p = reg[rreg_p], or 0 when rreg_p = 0.
  - rbusy_p = busy[rreg_p].
  - BYPASS=1, regWrite=1, wreg = rreg_p ≠ 0: rdata_p = wdata and rbusy_p = 0.
  - Exception: if a granted reservation targets the same register in that cycle, rbusy_p still shows the current busy bit.
- Reservation handshake:
  - rsvGrant = reserve & ~flush & (rsvReg = 0 | ~busy[rsvReg] | (regWrite & wreg = rsvReg)).
  - On a granted edge with rsvReg≠0, busy[rsvReg] ← 1.
  - A request for reg 0 is granted with no state change.
  - A request for a busy register is not granted. The requester holds reserve and rsvReg until granted; the block keeps no request memory.
- Simultaneous write and granted reserve to the same register: the data is written and busy ends at 1 (reserve wins).
- Flush: on the edge with flush=1, all busy bits ← 0 and busyCount ← 0. Any write in the same cycle still commits. Reserve is not granted.
- busyCount: registered counter, updated each edge by +1 for each 0→1 busy transition and −1 for each 1→0 busy transition, so it always equals the popcount of the busy bits. Range 0..NUMOFREGS−1.
- Reset (rst_n=0, asynchronous):
  - all registers ← 0, all busy ← 0, busyCount ← 0
  - rdata = 0, rbusy = 0 on every port
  - rsvGrant = 0 while held, regardless of reserve
  - Reset asserted mid-sequence discards all reservations immediately.

## Timing
- Write latency: 1 edge. With BYPASS=0, data is visible on rdata the cycle after the write edge. With BYPASS=1, it is visible combinationally in the write cycle.
- Busy set: visible on rbusy and busyCount the cycle after the grant edge.
- Busy clear (write or flush): visible the cycle after the edge, or in the write cycle when BYPASS=1 forwards the write.
- rsvGrant is purely combinational from current inputs and state; no registered acknowledge.
- Release after reset: the first edge with rst_n=1 may perform a write or a reservation.

## Test plan
- Write every reg r with 32'hFFFFFFFF>>r, then read all regs on all ports (port p reads r and 31−r) -> rdata = written value, reg 0 = 0, rbusy = 0 everywhere.
- Reserve reg 5 -> rsvGrant=1, next cycle rbusy=1 for reg 5 and busyCount=1. Reserve reg 5 again -> rsvGrant=0. Write 32'hA5A5A5A5 to reg 5 -> busy clears, busyCount=0, rdata=32'hA5A5A5A5.
- BYPASS=1: write 32'h12345678 to reg 7 while a port reads reg 7 -> same-cycle rdata=32'h12345678. BYPASS=0 build -> old value, then new value the next cycle.
- Reserve regs 1, 2, 3 (busyCount=3), then flush with a write to reg 2 and reserve of reg 4 in the same cycle -> rsvGrant=0, all busy 0, busyCount=0, reg 2 holds the written data.
- Busy reg 9 written and reserved in the same cycle -> rsvGrant=1, data updated, busy stays 1, busyCount unchanged.
- Assert rst_n=0 mid-operation with 4 regs busy -> all rdata, rbusy and busyCount read 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: multi-read-port register file with busy scoreboard.
// Issue reserves destinations, writeback releases them, reg 0 is hardwired.
module reg_file_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int NUMOFREGS  = 32,
    parameter int NUMRDPORTS = 2,
    parameter bit BYPASS     = 1'b1,
    localparam int AW        = $clog2(NUMOFREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        regWrite,
    input  logic [AW-1:0]               wreg,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [NUMRDPORTS*AW-1:0]    rreg,
    output logic [NUMRDPORTS*WIDTH-1:0] rdata,
    output logic [NUMRDPORTS-1:0]       rbusy,
    input  logic                        reserve,
    input  logic [AW-1:0]               rsvReg,
    output logic                        rsvGrant,
    input  logic                        flush,
    output logic [AW:0]                 busyCount
);

    logic [WIDTH-1:0]     regs_q [NUMOFREGS];
    logic [WIDTH-1:0]     regs_d [NUMOFREGS];
    logic [NUMOFREGS-1:0] busy_q;
    logic [NUMOFREGS-1:0] busy_d;
    logic [AW:0]          cnt_q;
    logic [AW:0]          cnt_d;

    logic wr_en;
    logic rsv_hit;
    logic rsv_set;
    logic set_ev;
    logic clr_ev;

    assign wr_en = regWrite && (wreg != '0);

    // A busy target may still be granted when writeback frees it this cycle.
    assign rsv_hit = (rsvReg == '0)
                   || !busy_q[rsvReg]
                   || (regWrite && (wreg == rsvReg));

    assign rsvGrant = rst_n && reserve && !flush && rsv_hit;
    assign rsv_set  = rsvGrant && (rsvReg != '0);

    // Counter events: only real 0->1 and 1->0 busy transitions count.
    assign set_ev = rsv_set && !busy_q[rsvReg];
    assign clr_ev = wr_en && busy_q[wreg]
                  && !(rsv_set && (rsvReg == wreg));

    // Next register contents: single write port, entry 0 held at zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wreg] = wdata;
        end
        regs_d[0] = '0;
    end

    // Next busy bits: writeback clears, flush clears all, reserve wins last.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wreg] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (rsv_set) begin
            busy_d[rsvReg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Next busy count tracks the popcount incrementally.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + (AW+1)'(set_ev) - (AW+1)'(clr_ev);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMOFREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busyCount = cnt_q;

    for (genvar p = 0; p < NUMRDPORTS; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        logic          hold;

        assign ra   = rreg[p*AW +: AW];
        assign fwd  = BYPASS && wr_en && (wreg == ra);
        assign hold = rsvGrant && (rsvReg == ra);

        assign rdata[p*WIDTH +: WIDTH] =
            (!rst_n || (ra == '0)) ? '0 :
            fwd                    ? wdata :
                                     regs_q[ra];

        assign rbusy[p] = rst_n
                        && ((fwd && !hold) ? 1'b0 : busy_q[ra]);
    end

endmodule
